ibex_data_axi4l_bridge: RTL and testbench
=========================================

# ibex_data_axi4l_bridge

Converts the Ibex data-side request/grant bus into AXI4-Lite master transactions on an `axi4l_if.master` port. It sits directly upstream of the AXI4-Lite slaves, either through the interconnect or point-to-point to the dual-port RAM. It supports one outstanding transaction, registers the request on grant, and keeps every AXI channel stable until its handshake completes. Read data and write/read errors are returned to the core as a one-cycle `data_rvalid_o` pulse.

## Interface
- `force_align`, default 1: when 1, `awaddr[1:0]` and `araddr[1:0]` are driven as 2'b00.
- `aclk`  in  1  clock; rising edge only; the same clock as `axi.aclk`.
- `areset`  in  1  asynchronous, active-high reset.
- `data_req_i`  in  1  core request.
- `data_gnt_o`  out  1  request accepted this cycle.
- `data_we_i`  in  1  1 = write, 0 = read.
- `data_be_i`  in  4  byte enables; map to `wstrb`.
- `data_addr_i`  in  32  byte address.
- `data_wdata_i`  in  32  write data.
- `data_rvalid_o`  out  1  one-cycle response pulse.
- `data_rdata_o`  out  32  read data; 0 for write responses.
- `data_err_o`  out  1  response error; valid with `data_rvalid_o`.
- `axi`  master  —  `axi4l_if.master`; drives `awaddr`/`awvalid`, `wdata`/`wstrb`/`wvalid`, `bready`, `araddr`/`arvalid`, `rready`; samples `awready`, `wready`, `bvalid`/`bresp`, `arready`, `rvalid`/`rdata`/`rresp`.

## Operation
- FSM states: IDLE, WR (AW and/or W pending), WAIT_B, RD (AR pending), WAIT_R.
- `data_gnt_o` = `data_req_i` && state==IDLE, combinational. It is never asserted in any other state.
- On grant:
  - Latch addr, we, be and wdata.
  - If we=1: go to WR and set `awvalid`=`wvalid`=1 from the next cycle.
  - If we=0: go to RD and set `arvalid`=1.
- WR state:
  - `aw_done` and `w_done` flags track the two handshakes independently.
  - `awvalid` drops the cycle after `awvalid&&awready`; `wvalid` drops the cycle after `wvalid&&wready`.
  - Both handshakes may occur in the same cycle or in either order.
  - When both are done (including within the same cycle), go to WAIT_B.
- WAIT_B: `bready`=1. On `bvalid&&bready`, register `data_err_o`=`bresp[1]` and `data_rdata_o`=0, pulse `data_rvalid_o` next cycle, and return to IDLE.
- RD state: `arvalid` held until `arready`, then go to WAIT_R.
- WAIT_R: `rready`=1. On `rvalid&&rready`, register `data_rdata_o`=`rdata` and `data_err_o`=`rresp[1]`, pulse `data_rvalid_o`, and return to IDLE.
- `bready` and `rready` are 0 in all other states. A B or R beat arriving outside its wait state is not accepted.
- `wstrb`=latched be. A write with be=0 is still issued on the bus.
- While a channel's valid is high, its addr/data/strb are constant.
- Error mapping: OKAY and EXOKAY give err 0; SLVERR and DECERR give err 1.

## Timing
- Reset values: all valids 0, `bready`=`rready`=0, `data_gnt_o`=0 (IDLE, no req), `data_rvalid_o`=0, `data_rdata_o`=0, `data_err_o`=0, state IDLE.
- Reset is asynchronous. Asserting it mid-transaction drops every valid and ready immediately, and the in-flight response is discarded.
- Latency against a zero-wait slave (always-ready, response registered one cycle), with grant at cycle 0:
  - Write: AW/W valid at cycle 1, `bvalid` at cycle 2, `data_rvalid_o` at cycle 3.
  - Read: AR at cycle 1, `rvalid` at cycle 2, `data_rvalid_o` at cycle 3.
- The state returns to IDLE in the same cycle `data_rvalid_o` is high. A new request can be granted in that cycle, so back-to-back throughput is 1 transaction per 3 cycles.
- `data_rvalid_o` is exactly one cycle wide per grant: no loss, no duplicates.

## Test plan
- Write 0x0000_0010 = 0xDEADBEEF, be=4'hF, zero-wait slave -> AW/W at cycle 1, `awaddr`=0x10, `wstrb`=F; `data_rvalid_o` at cycle 3 with err=0.
- Read back 0x10 -> `araddr`=0x10; `data_rdata_o`=0xDEADBEEF at cycle 3, err=0.
- `awready` delayed 3 cycles while `wready`=1 -> `wvalid` drops after 1 cycle; `awvalid`/`awaddr` held stable 4 cycles; a single response is returned.
- `bresp`=SLVERR on a write and `rresp`=DECERR on a read -> err=1 on each pulse; `data_rdata_o`=0 for the write.
- `data_req_i` held high continuously during a read with 5-cycle `rvalid` delay -> no grant until the cycle of `data_rvalid_o`; the next request is granted in that cycle.
- `areset` asserted while in WAIT_R with `rvalid` pending -> all valids/readies 0 at once; no `data_rvalid_o`; after release the next grant works normally.

Source files
------------

// File: rtl/axi4l_if.sv
// AXI4-Lite bus bundle. The master modport is the bridge side and the slave modport is the memory/peripheral side.
interface axi4l_if (
    input logic aclk
);
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        input  aclk,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  aclk,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/ibex_data_axi4l_bridge.sv
// Converts the Ibex data request/grant bus into AXI4-Lite master transactions.
// Only one transaction is outstanding at a time. The response returns to the core as a one-cycle rvalid pulse.
module ibex_data_axi4l_bridge #(
    parameter bit force_align = 1'b1
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    axi4l_if.master     axi
);
    typedef enum logic [2:0] {IDLE, WR, WAIT_B, RD, WAIT_R} state_e;

    state_e      state_q, state_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic [31:0] bus_addr;

    assign data_gnt_o = data_req_i && (state_q == IDLE);
    assign bus_addr   = force_align ? {addr_q[31:2], 2'b00} : addr_q;

    // The valid and ready signals decode directly from registered state, so an async reset clears them at once.
    assign axi.awaddr  = bus_addr;
    assign axi.awvalid = (state_q == WR) && !aw_done_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = be_q;
    assign axi.wvalid  = (state_q == WR) && !w_done_q;
    assign axi.bready  = (state_q == WAIT_B);
    assign axi.araddr  = bus_addr;
    assign axi.arvalid = (state_q == RD);
    assign axi.rready  = (state_q == WAIT_R);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (data_req_i) state_d = data_we_i ? WR : RD;
            end
            WR: begin
                aw_done_d = aw_done_q | (axi.awvalid & axi.awready);
                w_done_d  = w_done_q  | (axi.wvalid  & axi.wready);
                if (aw_done_d && w_done_d) state_d = WAIT_B;
            end
            WAIT_B: if (axi.bvalid) state_d = IDLE;
            RD:     if (axi.arready) state_d = WAIT_R;
            WAIT_R: if (axi.rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            data_rvalid_o <= 1'b0;
            data_rdata_o  <= '0;
            data_err_o    <= 1'b0;
        end else begin
            data_rvalid_o <= 1'b0;
            if (data_gnt_o) begin
                addr_q  <= data_addr_i;
                wdata_q <= data_wdata_i;
                be_q    <= data_be_i;
            end
            // bresp/rresp bit 1 is set for SLVERR and DECERR and clear for OKAY and EXOKAY.
            if (state_q == WAIT_B && axi.bvalid) begin
                data_rvalid_o <= 1'b1;
                data_rdata_o  <= '0;
                data_err_o    <= axi.bresp[1];
            end else if (state_q == WAIT_R && axi.rvalid) begin
                data_rvalid_o <= 1'b1;
                data_rdata_o  <= axi.rdata;
                data_err_o    <= axi.rresp[1];
            end
        end
    end
endmodule

// File: tb/tb_ibex_data_axi4l_bridge.sv
// Bench for ibex_data_axi4l_bridge: a behavioural AXI4-Lite slave with configurable stalls and responses.
// A scoreboard of expected core responses is popped on every data_rvalid_o pulse.
module tb_ibex_data_axi4l_bridge;
    logic        aclk = 1'b0;
    logic        areset = 1'b0;
    logic        data_req_i = 1'b0;
    logic        data_gnt_o;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = '0;
    logic [31:0] data_addr_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    axi4l_if axi (.aclk(aclk));

    ibex_data_axi4l_bridge #(.force_align(1'b1)) dut (
        .aclk(aclk), .areset(areset),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .axi(axi)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    int          aw_w, w_w, ar_w, r_tmr, aw_total;
    logic        got_aw, got_w, s_bvalid, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_awaddr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [31:0] smem [0:255];
    logic [31:0] ref_mem [0:255];
    logic        aw_hs, w_hs, ar_hs;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;

    assign axi.awready = (aw_w >= aw_dly);
    assign axi.wready  = (w_w >= w_dly);
    assign axi.arready = (ar_w >= ar_dly);
    assign axi.bvalid  = s_bvalid;
    assign axi.bresp   = s_bresp;
    assign axi.rvalid  = s_rvalid;
    assign axi.rresp   = s_rresp;
    assign axi.rdata   = s_rdata;
    assign aw_hs   = axi.awvalid && axi.awready;
    assign w_hs    = axi.wvalid && axi.wready;
    assign ar_hs   = axi.arvalid && axi.arready;
    assign wr_addr = aw_hs ? axi.awaddr : s_awaddr;
    assign wr_data = w_hs ? axi.wdata : s_wdata;
    assign wr_strb = w_hs ? axi.wstrb : s_wstrb;

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_w <= 0; w_w <= 0; ar_w <= 0; r_tmr <= 0;
            got_aw <= 1'b0; got_w <= 1'b0; s_bvalid <= 1'b0; s_rvalid <= 1'b0;
            s_bresp <= 2'b00; s_rresp <= 2'b00; s_rdata <= '0;
            s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0;
        end else begin
            aw_w <= (axi.awvalid && !axi.awready) ? aw_w + 1 : 0;
            w_w  <= (axi.wvalid && !axi.wready) ? w_w + 1 : 0;
            ar_w <= (axi.arvalid && !axi.arready) ? ar_w + 1 : 0;
            if (aw_hs) begin got_aw <= 1'b1; s_awaddr <= axi.awaddr; aw_total <= aw_total + 1; end
            if (w_hs) begin got_w <= 1'b1; s_wdata <= axi.wdata; s_wstrb <= axi.wstrb; end
            if ((got_aw || aw_hs) && (got_w || w_hs)) begin
                got_aw <= 1'b0; got_w <= 1'b0;
                s_bvalid <= 1'b1; s_bresp <= bresp_cfg;
                for (int b = 0; b < 4; b++)
                    if (wr_strb[b]) smem[wr_addr[9:2]][8*b +: 8] <= wr_data[8*b +: 8];
            end
            if (s_bvalid && axi.bready) s_bvalid <= 1'b0;
            if (ar_hs) begin
                s_rdata <= smem[axi.araddr[9:2]];
                s_rresp <= rresp_cfg;
                if (r_dly == 0) s_rvalid <= 1'b1;
                else r_tmr <= r_dly;
            end
            if (r_tmr > 0) begin
                r_tmr <= r_tmr - 1;
                if (r_tmr == 1) s_rvalid <= 1'b1;
            end
            if (s_rvalid && axi.rready) s_rvalid <= 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          gcyc;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always @(negedge aclk) begin
        if (!areset && data_rvalid_o) begin
            if (sb.size() == 0) chk("spurious_rvalid", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("rdata", data_rdata_o, e.rdata);
                chk("err", data_err_o, e.err);
                if (e.lat > 0) chk("latency", cyc - e.gcyc, e.lat);
            end
        end
    end

    task automatic exp_push(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input logic [1:0] resp, input int lat);
        exp_t e;
        e.err  = resp[1];
        e.gcyc = cyc;
        e.lat  = lat;
        if (we) begin
            bresp_cfg = resp;
            e.rdata = '0;
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
        end else begin
            rresp_cfg = resp;
            e.rdata = ref_mem[addr[9:2]];
        end
        sb.push_back(e);
    endtask

    // Call at a negedge; returns at the negedge of the cycle after the grant.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [1:0] resp, input int lat);
        int n = 0;
        data_req_i = 1'b1; data_we_i = we; data_addr_i = addr;
        data_wdata_i = wdata; data_be_i = be;
        #1;
        while (!data_gnt_o && n < 100) begin
            @(negedge aclk); #1; n++;
        end
        if (!data_gnt_o) begin
            chk("gnt_timeout", 0, 1);
            data_req_i = 1'b0;
        end else begin
            exp_push(we, addr, wdata, be, resp, lat);
            @(negedge aclk);
            data_req_i = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge aclk); #2; n++;
        end
        if (sb.size() != 0) begin
            chk("rsp_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge aclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        for (int i = 0; i < 256; i++) begin smem[i] = '0; ref_mem[i] = '0; end
        aw_total = 0;
        #1 areset = 1'b1;
        #1;
        chk("reset_ctl", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready,
                          data_gnt_o, data_rvalid_o, data_err_o}, 8'h00);
        chk("reset_rdata", data_rdata_o, 32'h0);
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);

        // zero-wait write: AW/W one cycle after the grant
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2'b00, 3);
        #1;
        chk("wr_valids", {axi.awvalid, axi.wvalid}, 2'b11);
        chk("awaddr", axi.awaddr, 32'h10);
        chk("wstrb", axi.wstrb, 4'hF);
        chk("wdata", axi.wdata, 32'hDEADBEEF);
        wait_done();

        issue(1'b0, 32'h10, 32'h0, 4'hF, 2'b00, 3);
        #1;
        chk("arvalid", axi.arvalid, 1'b1);
        chk("araddr", axi.araddr, 32'h10);
        wait_done();

        // AW stalled three cycles while W is accepted immediately
        aw_dly = 3;
        issue(1'b1, 32'h20, 32'h12345678, 4'h3, 2'b00, 6);
        #1;
        chk("stall_c1_aw", {axi.awvalid, axi.wvalid}, 2'b11);
        for (int c = 2; c <= 4; c++) begin
            @(negedge aclk); #1;
            chk("stall_aw_held", {axi.awvalid, axi.wvalid}, 2'b10);
            chk("stall_awaddr", axi.awaddr, 32'h20);
        end
        @(negedge aclk); #1;
        chk("stall_aw_drop", axi.awvalid, 1'b0);
        wait_done();
        aw_dly = 0;
        issue(1'b0, 32'h20, 32'h0, 4'hF, 2'b00, 3);
        wait_done();

        // response error mapping
        issue(1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 2'b10, 3);
        wait_done();
        issue(1'b0, 32'h10, 32'h0, 4'hF, 2'b11, 3);
        wait_done();
        issue(1'b0, 32'h30, 32'h0, 4'hF, 2'b01, 3);
        wait_done();
        bresp_cfg = 2'b00; rresp_cfg = 2'b00;

        // write with be=0 still reaches the bus and leaves memory unchanged
        base = aw_total;
        issue(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 2'b00, 3);
        #1;
        chk("be0_wstrb", axi.wstrb, 4'h0);
        wait_done();
        chk("be0_issued", aw_total - base, 1);

        // unaligned address is forced to word alignment
        issue(1'b0, 32'h13, 32'h0, 4'hF, 2'b00, 3);
        #1;
        chk("align_araddr", axi.araddr, 32'h10);
        wait_done();

        // req held high through a slow read: next grant lands in the rvalid cycle
        r_dly = 5;
        data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h20; data_be_i = 4'hF;
        #1;
        chk("hold_gnt0", data_gnt_o, 1'b1);
        exp_push(1'b0, 32'h20, 32'h0, 4'hF, 2'b00, 8);
        for (int c = 1; c <= 7; c++) begin
            @(negedge aclk); #1;
            chk("hold_no_gnt", data_gnt_o, 1'b0);
        end
        @(negedge aclk); #1;
        chk("hold_gnt_rvalid", {data_gnt_o, data_rvalid_o}, 2'b11);
        r_dly = 0;
        data_addr_i = 32'h30;
        exp_push(1'b0, 32'h30, 32'h0, 4'hF, 2'b00, 3);
        @(negedge aclk);
        data_req_i = 1'b0;
        wait_done();

        // reset while waiting on R discards the response
        r_dly = 5;
        issue(1'b0, 32'h10, 32'h0, 4'hF, 2'b00, 0);
        @(negedge aclk);
        @(negedge aclk); #1;
        chk("pre_rst_rready", axi.rready, 1'b1);
        #1 areset = 1'b1;
        #1;
        chk("mid_rst_ctl", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready,
                            data_gnt_o, data_rvalid_o}, 7'h00);
        sb.delete();
        r_dly = 0;
        @(negedge aclk);
        areset = 1'b0;
        repeat (8) @(negedge aclk);
        issue(1'b0, 32'h10, 32'h0, 4'hF, 2'b00, 3);
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
